regfile_scoreboard: RTL
=======================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter WIDTH, default 16: data width of every register and data port.
REQ-002 Parameter NREGS, default 4: register count, power of two, at least 2; AW = clog2(NREGS).
REQ-003 Parameter SCOREBOARD, default 1: 1 enables busy tracking and stall; 0 gives plain register-file mode.
REQ-004 Port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port rr1, input, AW: read address, port 1.
REQ-007 Port rr2, input, AW: read address, port 2.
REQ-008 Port rd1, output, WIDTH: read data, port 1.
REQ-009 Port rd2, output, WIDTH: read data, port 2.
REQ-010 Port regwrite, input, 1: writeback strobe.
REQ-011 Port wr, input, AW: writeback address.
REQ-012 Port wd, input, WIDTH: writeback data.
REQ-013 Port issue, input, 1: an instruction reads rr1/rr2 and will later write issue_rd.
REQ-014 Port issue_rd, input, AW: destination register of the issuing instruction.
REQ-015 Port stall, output, 1: the issue is refused this cycle.
REQ-016 Port busy, output, NREGS: pending-write bit per register; bit 0 is always 0.

Function
REQ-017 Register 0 SHALL read as zero; writes, issues and busy-set to it SHALL be ignored.
REQ-018 Writes: on a rising edge with regwrite=1 and wr!=0, register wr SHALL load wd.
REQ-019 Reads SHALL be combinational with zero latency.
REQ-020 Bypass: if regwrite=1, wr!=0 and wr==rrN, rdN SHALL equal wd in the same cycle.
REQ-021 Effective busy SHALL be busy with bit wr cleared when regwrite=1.
REQ-022 stall SHALL be issue AND (ebusy[rr1] OR ebusy[rr2] OR ebusy[issue_rd]), where ebusy is effective busy; register 0 never contributes.
REQ-023 Busy set: on a rising edge with issue=1, stall=0 and issue_rd!=0, busy[issue_rd] SHALL be set.
REQ-024 Busy clear: on a rising edge with regwrite=1, busy[wr] SHALL be cleared.
REQ-025 If the edge both clears and sets the same bit, set SHALL win (the new producer owns the register).
REQ-026 Writeback to a non-busy register SHALL be legal and write normally.
REQ-027 An issue with stall=1 SHALL change no state; the requester holds the request and retries.
REQ-028 With SCOREBOARD=0, busy SHALL be constant 0 and stall constant 0; all read and write behaviour is unchanged.

Reset
REQ-029 reset_n=0 SHALL immediately clear all registers and all busy bits, independent of clock.
REQ-030 During reset, stall SHALL be 0 and rd1/rd2 SHALL read 0, except that a bypass per REQ-020 SHALL still drive wd.
REQ-031 Reset asserted mid-operation SHALL drop all pending writes; the first rising edge after deassertion SHALL behave as a normal cycle.

Structure
REQ-032 Package cpu_pkg SHALL hold the WIDTH/NREGS defaults and the register-address typedef shared with the CPU datapath.
REQ-033 One sub-module, reg_en, SHALL be used: a WIDTH-bit register with write enable and asynchronous active-low clear, instantiated per register 1..NREGS-1.
REQ-034 The busy vector and stall logic SHALL live in the top module.

Verification (WIDTH=16, NREGS=4)
REQ-035 Reset, then read all ports -> rd1=rd2=0, busy=0000, stall=0; write wr=0, wd=16'hFFFF, then read r0 -> 0.
REQ-036 Issue issue_rd=2 -> busy=0100; next cycle issue with rr1=2 -> stall=1, busy unchanged; regwrite wr=2, wd=16'h0007 -> busy=0000, and a retried issue in that same cycle does not stall and reads rd1=16'h0007.
REQ-037 Same edge: regwrite wr=3 and issue issue_rd=3 -> busy[3] remains 1; r3 holds the written value.
REQ-038 Bypass: regwrite wr=1, wd=16'h1234, rr1=rr2=1 -> rd1=rd2=16'h1234 in the same cycle, before the edge.
REQ-039 Reset pulse while busy=1110 -> busy=0000 and registers 0 before the next clock edge.
REQ-040 SCOREBOARD=0 build: repeat REQ-036 stimulus -> stall never asserts, busy stays 0, data results identical.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default register-file geometry and the register
// address type used by the datapath, plus a small parameter helper.
//   WIDTH_DEF  : default data width
//   NREGS_DEF  : default register count
//   reg_addr_t : register address for the default geometry
package cpu_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int NREGS_DEF = 4;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bus between the CPU issue/writeback logic and the register file.
//   master : drives read addresses, writeback and issue requests
//   slave  : returns read data, stall and the busy vector
interface regfile_scoreboard_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = NREGS_DEF
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]    rr1;
  logic [AW-1:0]    rr2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             regwrite;
  logic [AW-1:0]    wr;
  logic [WIDTH-1:0] wd;
  logic             issue;
  logic [AW-1:0]    issue_rd;
  logic             stall;
  logic [NREGS-1:0] busy;

  modport master (
    output rr1, rr2, regwrite, wr, wd, issue, issue_rd,
    input  rd1, rd2, stall, busy
  );

  modport slave (
    input  rr1, rr2, regwrite, wr, wd, issue, issue_rd,
    output rd1, rd2, stall, busy
  );

endinterface

// File: rtl/reg_en.sv
// WIDTH-bit register with write enable and asynchronous active-low clear.
//   clock, reset_n : clock and async clear
//   en, d          : load d on the rising edge when en is high
//   q              : register contents
module reg_en #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read / one-write register file with write-through bypass and an
// optional busy scoreboard that stalls issues with pending hazards.
//   clock, reset_n : clock and async active-low reset
//   bus (slave)    : rr1/rr2 -> rd1/rd2 combinational reads,
//                    regwrite/wr/wd writeback,
//                    issue/issue_rd request -> stall, busy vector
// Register 0 is hardwired to zero and is never marked busy.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int NREGS      = NREGS_DEF,
  parameter bit SCOREBOARD = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  regfile_scoreboard_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  if (NREGS < 2 || !is_pow2(NREGS)) begin : g_bad_nregs
    $error("regfile_scoreboard: NREGS must be a power of two >= 2");
  end

  logic [WIDTH-1:0] regs [NREGS];
  logic             wr_valid;

  assign wr_valid = bus.regwrite && (bus.wr != '0);
  assign regs[0]  = '0;

  for (genvar i = 1; i < NREGS; i++) begin : g_reg
    reg_en #(.WIDTH(WIDTH)) u_reg (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (wr_valid && (bus.wr == AW'(i))),
      .d       (bus.wd),
      .q       (regs[i])
    );
  end

  // Write-through bypass so a consumer can pick up a result in the same
  // cycle it is written back, even while reset holds the array clear.
  assign bus.rd1 = (wr_valid && (bus.wr == bus.rr1)) ? bus.wd : regs[bus.rr1];
  assign bus.rd2 = (wr_valid && (bus.wr == bus.rr2)) ? bus.wd : regs[bus.rr2];

  if (SCOREBOARD) begin : g_sb
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] ebusy;
    logic             stall_int;

    // Bit 0 of both masks stays 0, so r0 never becomes busy and never stalls.
    always_comb begin
      clr_mask = '0;
      set_mask = '0;
      for (int i = 1; i < NREGS; i++) begin
        clr_mask[i] = bus.regwrite && (bus.wr == AW'(i));
        set_mask[i] = bus.issue && (bus.issue_rd == AW'(i));
      end
    end

    // A writeback in this cycle already resolves its hazard.
    assign ebusy = busy_q & ~clr_mask;

    assign stall_int = bus.issue &&
                       (ebusy[bus.rr1] || ebusy[bus.rr2] || ebusy[bus.issue_rd]);

    // Set is ORed after the clear so a new producer owns the register.
    assign busy_d = ebusy | (set_mask & {NREGS{~stall_int}});

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        busy_q <= '0;
      end else begin
        busy_q <= busy_d;
      end
    end

    assign bus.busy  = busy_q;
    assign bus.stall = stall_int;
  end else begin : g_plain
    assign bus.busy  = '0;
    assign bus.stall = 1'b0;
  end

endmodule
